// File: rtl/inst_cache_tag_assoc.sv
// Set-associative instruction-cache tag/valid store with combinational lookup,
// per-set round-robin victim selection and a sequenced whole-cache flush.
module inst_cache_tag_assoc #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_BITS   = 22,
    localparam int unsigned WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] lookup_index,
    input  logic [TAG_BITS-1:0]   lookup_tag,
    output logic                  hit,
    output logic [WAY_BITS-1:0]   hit_way,
    input  logic                  fill_we,
    input  logic [INDEX_BITS-1:0] fill_index,
    input  logic [TAG_BITS-1:0]   fill_tag,
    output logic [WAY_BITS-1:0]   victim_way,
    input  logic                  flush_req,
    output logic                  flush_busy
);

    localparam int unsigned SETS = 2 ** INDEX_BITS;

    typedef enum logic {
        StIdle,
        StFlush
    } state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] flush_idx_q, flush_idx_d;

    // Tags carry no reset; only valid bits and round-robin pointers are cleared.
    logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAY_BITS-1:0] rr_q    [SETS];

    logic                hit_c;
    logic [WAY_BITS-1:0] hit_way_c;
    logic                victim_found;
    logic [WAY_BITS-1:0] victim_c;
    logic                fill_set_full;
    logic [WAY_BITS-1:0] rr_next;

    assign flush_busy = (state_q == StFlush);

    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_c && valid_q[lookup_index][w] && (tag_q[lookup_index][w] == lookup_tag)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_BITS'(w);
            end
        end
    end

    assign hit     = hit_c && !flush_busy;
    assign hit_way = hit ? hit_way_c : '0;

    always_comb begin
        victim_found = 1'b0;
        victim_c     = rr_q[fill_index];
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_q[fill_index][w]) begin
                victim_found = 1'b1;
                victim_c     = WAY_BITS'(w);
            end
        end
    end

    assign fill_set_full = &valid_q[fill_index];
    assign victim_way    = (WAYS == 1) ? '0 : victim_c;
    // WAYS is a power of two, so the natural WAY_BITS wrap is modulo WAYS except for WAYS=1.
    assign rr_next       = (WAYS == 1) ? '0 : rr_q[fill_index] + WAY_BITS'(1);

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        unique case (state_q)
            StIdle: begin
                if (flush_req) begin
                    state_d     = StFlush;
                    flush_idx_d = '0;
                end
            end
            StFlush: begin
                if (&flush_idx_q) begin
                    state_d = StIdle;
                end else begin
                    flush_idx_d = flush_idx_q + INDEX_BITS'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StFlush;
            flush_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if ((state_q == StIdle) && fill_we) begin
                tag_q[fill_index][victim_way]   <= fill_tag;
                valid_q[fill_index][victim_way] <= 1'b1;
                if (fill_set_full) begin
                    rr_q[fill_index] <= rr_next;
                end
            end
            if (state_q == StFlush) begin
                valid_q[flush_idx_q] <= '0;
                rr_q[flush_idx_q]    <= '0;
            end
        end
    end

endmodule

// File: doc/inst_cache_tag_assoc.md
Name: inst_cache_tag_assoc

Overview:
Parametrised set-associative tag/valid store for the instruction cache. It is the successor to the direct-mapped tag RAM.
- Adds N-way hit detection, per-set round-robin victim selection and a sequenced whole-cache invalidate (flush).
- Sits between the fetch stage, which does the lookup, and the icache fill controller, which does the fill and flush.
- Lookup is combinational. All state updates happen on the rising edge of clock.

Parameters:
WAYS, 2, associativity; power of two, 1..8.
INDEX_BITS, 6, set index width; SETS = 2**INDEX_BITS.
TAG_BITS, 22, stored tag width.
WAY_BITS, derived, = max(1, clog2(WAYS)); not user-overridable.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
lookup_index  in  INDEX_BITS  set addressed by fetch.
lookup_tag  in  TAG_BITS  tag compared against the addressed set.
hit  out  1  some valid way in lookup_index matches lookup_tag; forced 0 while flush_busy.
hit_way  out  WAY_BITS  matching way; lowest-numbered match if several; 0 when hit=0.
fill_we  in  1  write one way of a set this cycle.
fill_index  in  INDEX_BITS  set to fill.
fill_tag  in  TAG_BITS  tag written; the valid bit is written 1.
victim_way  out  WAY_BITS  way that a fill to fill_index will use (combinational).
flush_req  in  1  single-cycle request to invalidate all sets.
flush_busy  out  1  flush sequence in progress.

Behaviour:
- Storage:
  - tag[SETS][WAYS], valid[SETS][WAYS], rr_ptr[SETS] (WAY_BITS each).
  - Tags are not cleared by reset or flush; only valid bits and rr_ptr are.
- Lookup: purely combinational from the current register contents; zero latency.
  - A fill or flush write in cycle N is visible to lookup in cycle N+1.
  - A same-cycle lookup of the set being written returns the old contents.
- Victim selection, combinational on fill_index:
  - If any way is invalid, victim_way is the lowest-numbered invalid way.
  - Otherwise victim_way is rr_ptr[fill_index].
- Fill: when fill_we=1 and state=IDLE, at the clock edge:
  - tag[fill_index][victim_way] <= fill_tag;
  - valid[fill_index][victim_way] <= 1;
  - if all ways were valid before the write, rr_ptr[fill_index] <= rr_ptr + 1 (mod WAYS); otherwise rr_ptr is unchanged.
  - fill_we is ignored when state=FLUSH.
- WAYS=1 degenerates to direct-mapped: victim_way=0 and hit_way=0 always.
- FSM has two states, IDLE and FLUSH, with a counter flush_idx (INDEX_BITS).
  - IDLE: flush_req=1 -> FLUSH, flush_idx<=0.
  - FLUSH: each cycle, valid[flush_idx][all ways] <= 0 and rr_ptr[flush_idx] <= 0.
    - If flush_idx==SETS-1, go to IDLE; otherwise flush_idx <= flush_idx+1.
  - A flush takes exactly SETS cycles in FLUSH.
  - flush_req while in FLUSH is ignored; it does not restart the sequence.
  - flush_req and fill_we in the same IDLE cycle: the fill is performed, then the flush starts and clears it.
- flush_busy = (state==FLUSH), registered state decode with no combinational path from flush_req.
- Reset, synchronous, has priority over everything:
  - state<=FLUSH, flush_idx<=0, so flush_busy=1 in the cycle after reset is sampled.
  - After reset deasserts, SETS more FLUSH cycles run, then IDLE.
  - Reset asserted mid-flush restarts the sequence at index 0.
  - Reset outputs: flush_busy=1, hit=0, hit_way=0.
  - victim_way follows the rr/valid contents.
  - Reset does not clear valid bits in the reset cycle itself; they are cleared by the sequence.
- Contents before the first completed flush are don't-care. hit is masked during this period by flush_busy.
- Widths: rr_ptr increments wrap modulo WAYS. flush_idx wraps only via the terminal compare.

Test Plan:
1. Reset 2 cycles, then release (WAYS=2, INDEX_BITS=6) -> flush_busy=1 for exactly 64 cycles after release, then 0; hit=0 throughout; afterwards lookup of any index/tag gives hit=0.
2. Fill idx 5, tag 0x1234; next cycle lookup idx 5, tag 0x1234 -> hit=1, hit_way=0. Fill idx 5, tag 0x0BEEF -> goes to way 1; lookup 0x0BEEF -> hit_way=1. Same-cycle lookup during the second fill -> hit=0 for 0x0BEEF.
3. Set 5 full, rr_ptr=0: fill tags 0x7, 0x8, 0x9 in turn -> victim ways 0, 1, 0. Each evicted tag misses next cycle; rr_ptr for set 5 is 1 at the end.
4. Fill sets 0, 31 and 63; pulse flush_req -> flush_busy=1 for 64 cycles. fill_we during the flush leaves set 10 invalid. After the flush, all three earlier fills miss and victim_way=0 for every set.
5. Flush in progress at flush_idx=20; assert reset 1 cycle -> the sequence restarts at 0, and flush_busy stays 1 for 64 cycles after reset release.
6. WAYS=4, INDEX_BITS=2 build: fill the same set 6 times -> ways 0, 1, 2, 3, 0, 1 used. A duplicate tag present in ways 1 and 3 (forced) -> hit_way=1.
